pwm_dac: RTL and testbench
==========================

// Module: pwm_dac
// PURPOSE
//  Sink end of the synth audio sample path: accepts unsigned 8-bit samples
//  (oscillator/mixer output) over a valid/ready handshake and converts them to
//  a 1-bit PWM stream that drives the board's RC-filtered audio pin.
//  Holds one sample in a pending buffer; the PWM duty updates only at frame
//  boundaries, so the output never glitches mid-frame.
// PARAMETERS
//  WIDTH  8  sample width; frame length FRAME = 2**WIDTH-1 clocks (255)
// PORTS
//  clk           in   1      system clock, all logic on posedge
//  nRst          in   1      reset, synchronous, active-low
//  enable        in   1      1 = run PWM; 0 = output forced low, frame counter parked
//  sample_valid  in   1      producer has a sample on sample_data
//  sample_data   in   WIDTH  unsigned sample (duty in clocks per frame)
//  sample_ready  out  1      block can accept a sample this cycle
//  pwm_out       out  1      registered PWM output
//  frame_start   out  1      1-cycle pulse on the cycle the duty register loads
//  underrun      out  1      1-cycle pulse: frame boundary with pending buffer empty
// BEHAVIOUR
//  Reset (nRst=0 at posedge): count=MAX (MAX=FRAME-1=254), duty=0, pending empty,
//   pwm_out=0, frame_start=0, underrun=0; sample_ready=1 in the following cycle.
//  Registers: count[WIDTH-1:0], duty[WIDTH-1:0], pend_data[WIDTH-1:0], pend_full.
//  States: IDLE (enable=0) / RUN (enable=1); state is enable itself, no extra FSM reg.
//  Handshake: transfer when sample_valid && sample_ready at posedge.
//   sample_ready = !pend_full || load  (combinational; load defined below).
//   Transfer writes pend_data and sets pend_full. sample_data is ignored when
//   sample_valid=0; valid without ready holds off, no data lost, no drop.
//  Frame counter (RUN): load = enable && (count==MAX).
//   load: count<=0, duty<=pend_full ? pend_data : duty (held), pend_full cleared
//   unless a transfer happens in the same cycle (then refilled with new data).
//   else count<=count+1. Frame = counts 0..MAX = 255 clocks.
//  IDLE: count<=MAX, duty held, pwm_out<=0, no load, no pulses; handshake still
//   works (buffer fills, then ready=0). The first RUN cycle is a load cycle, so
//   a re-enabled stream starts a fresh frame with the pending sample.
//  Output: pwm_out <= enable && (count_next < duty_next), i.e. registered, one clock
//   behind the counter; high for exactly duty clocks of each frame, starting at
//   frame offset 0. duty=0 -> constant 0; duty=255 -> constant 1 (no gap at wrap).
//  frame_start <= load. underrun <= load && !pend_full (before any same-cycle
//   transfer; a sample arriving on the load cycle still counts as underrun).
//  Reset mid-frame: all state returns to reset values next cycle; pending sample
//   discarded.
//  Arithmetic: all compares unsigned WIDTH-bit; count never exceeds MAX.
// TESTING
//  1 reset: nRst=0 2 clk, valid=0 -> pwm_out=0, frame_start=0, underrun=0, ready=1.
//  2 enable=1, push 64 in IDLE -> first frame_start, then exactly 64 clk high,
//    191 low, period 255, repeating while 64 is re-held (underrun each frame).
//  3 push 0 then 255 on successive frames -> frame all-low, then 255 clk high with
//    pwm_out continuously 1 across following boundaries while 255 held.
//  4 mid-frame push A,B,C back-to-back, valid held -> A accepted, ready=0 until
//    load; B accepted on the load cycle (duty=A); C accepted at next load (duty=B).
//  5 one sample then none -> underrun pulse at every later frame_start, duty held.
//  6 enable 1->0 mid-frame with pending full -> pwm_out=0 next clk, ready=0;
//    enable back to 1 -> frame_start first clk, duty=pending, ready=1 again.

Source files
------------

// File: rtl/pwm_dac_if.sv
// -----------------------------------------------------------------------------
// pwm_dac_if
// Purpose : valid/ready sample channel that feeds unsigned audio samples into
//           the PWM DAC.
// Signals : sample_valid  producer -> DAC  a sample is present on sample_data
//           sample_data   producer -> DAC  unsigned sample (duty, clocks/frame)
//           sample_ready  DAC -> producer  DAC accepts a sample this cycle
// Modports: master = sample producer, slave = PWM DAC.
// -----------------------------------------------------------------------------
interface pwm_dac_if #(
    parameter int WIDTH = 8
) ();
    logic             sample_valid;
    logic [WIDTH-1:0] sample_data;
    logic             sample_ready;

    modport master (
        output sample_valid,
        output sample_data,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  sample_data,
        output sample_ready
    );
endinterface

// File: rtl/pwm_dac.sv
// -----------------------------------------------------------------------------
// pwm_dac
// Purpose : converts unsigned WIDTH-bit samples into a 1-bit PWM stream with a
//           frame of 2**WIDTH-1 clocks. One sample is buffered; the duty only
//           changes at frame boundaries so the output never glitches mid-frame.
// Ports   : clk          system clock (posedge)
//           nRst         synchronous active-low reset
//           enable       1 = run PWM, 0 = output low and frame counter parked
//           sample       sample channel (slave side of pwm_dac_if)
//           pwm_out      registered PWM output
//           frame_start  1-cycle pulse on the cycle the duty register loads
//           underrun     1-cycle pulse when a frame starts with no pending sample
// -----------------------------------------------------------------------------
module pwm_dac #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       enable,
    pwm_dac_if.slave   sample,
    output logic       pwm_out,
    output logic       frame_start,
    output logic       underrun
);

    // Last count of a frame: the frame runs 0..MAX, i.e. 2**WIDTH-1 clocks.
    localparam logic [WIDTH-1:0] MAX = {{(WIDTH-1){1'b1}}, 1'b0};

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_duty;
    logic [WIDTH-1:0] r_pend_data;
    logic             r_pend_full;

    logic             w_load;
    logic             w_ready;
    logic             w_xfer;
    logic [WIDTH-1:0] w_count_next;
    logic [WIDTH-1:0] w_duty_next;

    // Frame-boundary detect, handshake, and next counter/duty values.
    always_comb begin
        w_load       = 1'b0;
        w_ready      = 1'b0;
        w_xfer       = 1'b0;
        w_count_next = r_count;
        w_duty_next  = r_duty;

        // A parked counter sits at MAX, so the first enabled cycle is a load.
        w_load  = enable && (r_count == MAX);
        // The buffer frees up on a load cycle, so a sample may land there too.
        w_ready = !r_pend_full || w_load;
        w_xfer  = sample.sample_valid && w_ready;

        if (!enable) begin
            w_count_next = MAX;
        end else if (w_load) begin
            w_count_next = {WIDTH{1'b0}};
        end else begin
            w_count_next = r_count + {{(WIDTH-1){1'b0}}, 1'b1};
        end

        if (w_load && r_pend_full) begin
            w_duty_next = r_pend_data;
        end else begin
            w_duty_next = r_duty;
        end
    end

    assign sample.sample_ready = w_ready;

    // State registers: counter, duty, pending buffer and the registered outputs.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            r_count     <= MAX;
            r_duty      <= {WIDTH{1'b0}};
            r_pend_data <= {WIDTH{1'b0}};
            r_pend_full <= 1'b0;
            pwm_out     <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_duty  <= w_duty_next;

            // A same-cycle transfer refills the buffer the load just emptied.
            if (w_xfer) begin
                r_pend_data <= sample.sample_data;
                r_pend_full <= 1'b1;
            end else if (w_load) begin
                r_pend_data <= r_pend_data;
                r_pend_full <= 1'b0;
            end else begin
                r_pend_data <= r_pend_data;
                r_pend_full <= r_pend_full;
            end

            // Compare against next-state values so the output tracks the
            // counter exactly one clock behind; duty=MAX+1 never drops at wrap.
            pwm_out     <= enable && (w_count_next < w_duty_next);
            frame_start <= w_load;
            // Judged on the buffer before any same-cycle transfer.
            underrun    <= w_load && !r_pend_full;
        end
    end

endmodule

// File: tb/tb_pwm_dac.sv
// -----------------------------------------------------------------------------
// tb_pwm_dac
// Purpose : directed self-checking bench for pwm_dac; drives samples through
//           the pwm_dac_if channel and checks PWM shape, pulses and handshake
//           frame by frame against hand-computed values.
// -----------------------------------------------------------------------------
module tb_pwm_dac;

    logic clk = 1'b0;
    logic nRst;
    logic enable;
    logic pwm_out;
    logic frame_start;
    logic underrun;

    int n_vec = 0;
    int n_err = 0;

    // 10 ns system clock.
    always #5 clk = ~clk;

    pwm_dac_if #(.WIDTH(8)) bus ();

    pwm_dac #(.WIDTH(8)) dut (
        .clk         (clk),
        .nRst        (nRst),
        .enable      (enable),
        .sample      (bus),
        .pwm_out     (pwm_out),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Present one sample and hold valid until accepted (bounded wait).
    task automatic produce(input string tag, input logic [7:0] d, input int max_wait,
                           output int waited, output logic fs_at_acc);
        logic done;
        done      = 1'b0;
        waited    = 0;
        fs_at_acc = 1'b0;
        bus.sample_valid = 1'b1;
        bus.sample_data  = d;
        for (int k = 0; k < max_wait && !done; k++) begin
            #1;
            if (bus.sample_ready === 1'b1) begin
                @(posedge clk);
                @(negedge clk);
                fs_at_acc = frame_start;
                waited    = k;
                done      = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        check_eq({tag, ".accepted"}, {31'd0, done}, 32'd1);
    endtask

    // Observe one full 255-clock frame starting at the load edge.
    task automatic run_frame(input string tag, input int exp_high, input logic exp_ur);
        int   bad;
        int   hi;
        int   fs_n;
        int   ur_n;
        logic fs0;
        logic ur0;
        bad = 0; hi = 0; fs_n = 0; ur_n = 0; fs0 = 1'b0; ur0 = 1'b0;
        for (int i = 0; i < 255; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 0) begin
                fs0 = frame_start;
                ur0 = underrun;
            end
            fs_n += int'(frame_start);
            ur_n += int'(underrun);
            hi   += int'(pwm_out);
            if (pwm_out !== (i < exp_high)) bad++;
        end
        check_eq({tag, ".fs_first"}, {31'd0, fs0}, 32'd1);
        check_eq({tag, ".fs_count"}, fs_n, 32'd1);
        check_eq({tag, ".ur_first"}, {31'd0, ur0}, {31'd0, exp_ur});
        check_eq({tag, ".ur_count"}, ur_n, {31'd0, exp_ur});
        check_eq({tag, ".high"}, hi, exp_high);
        check_eq({tag, ".shape_err"}, bad, 32'd0);
    endtask

    int   w_a, w_b, w_c, w_x;
    logic f_a, f_b, f_c, f_x;

    initial begin
        nRst = 1'b0;
        enable = 1'b0;
        bus.sample_valid = 1'b0;
        bus.sample_data  = 8'd0;

        // Reset state.
        step(2);
        check_eq("rst.pwm", {31'd0, pwm_out}, 32'd0);
        check_eq("rst.fs", {31'd0, frame_start}, 32'd0);
        check_eq("rst.ur", {31'd0, underrun}, 32'd0);
        check_eq("rst.ready", {31'd0, bus.sample_ready}, 32'd1);

        // Push 64 while idle: buffer fills, output stays low.
        nRst = 1'b1;
        produce("p64", 8'd64, 4, w_x, f_x);
        bus.sample_valid = 1'b0;
        check_eq("p64.wait", w_x, 32'd0);
        #1;
        check_eq("idle.ready_full", {31'd0, bus.sample_ready}, 32'd0);
        step(3);
        check_eq("idle.pwm", {31'd0, pwm_out}, 32'd0);
        check_eq("idle.fs", {31'd0, frame_start}, 32'd0);

        // Enable: frame with 64 high, then 64 re-held with underrun.
        enable = 1'b1;
        run_frame("f1_64", 64, 1'b0);
        fork
            run_frame("f2_64held", 64, 1'b1);
            begin
                step(10);
                produce("p0", 8'd0, 4, w_x, f_x);
                bus.sample_valid = 1'b0;
            end
        join
        fork
            run_frame("f3_zero", 0, 1'b0);
            begin
                step(10);
                produce("p255", 8'd255, 4, w_x, f_x);
                bus.sample_valid = 1'b0;
            end
        join
        run_frame("f4_full", 255, 1'b0);
        // Back-to-back A,B,C with valid held throughout.
        fork
            begin
                run_frame("f5_full", 255, 1'b1);
                run_frame("f6_dutyA", 10, 1'b0);
                run_frame("f7_dutyB", 20, 1'b0);
            end
            begin
                step(20);
                produce("pa", 8'd10, 4, w_a, f_a);
                produce("pb", 8'd20, 300, w_b, f_b);
                produce("pc", 8'd30, 300, w_c, f_c);
                bus.sample_valid = 1'b0;
            end
        join
        check_eq("bb.a_wait", w_a, 32'd0);
        check_eq("bb.a_fs", {31'd0, f_a}, 32'd0);
        check_eq("bb.b_held_off", {31'd0, (w_b > 0)}, 32'd1);
        check_eq("bb.b_on_load", {31'd0, f_b}, 32'd1);
        check_eq("bb.c_wait", w_c, 32'd254);
        check_eq("bb.c_on_load", {31'd0, f_c}, 32'd1);
        run_frame("f8_dutyC", 30, 1'b0);
        // Starved: underrun every frame, duty held.
        run_frame("f9_starve", 30, 1'b1);
        run_frame("f10_starve", 30, 1'b1);

        // Disable mid-frame with pending full, then re-enable.
        step(3);
        produce("p100", 8'd100, 4, w_x, f_x);
        bus.sample_valid = 1'b0;
        check_eq("dis.pwm_before", {31'd0, pwm_out}, 32'd1);
        enable = 1'b0;
        step(1);
        check_eq("dis.pwm", {31'd0, pwm_out}, 32'd0);
        check_eq("dis.ready", {31'd0, bus.sample_ready}, 32'd0);
        check_eq("dis.fs", {31'd0, frame_start}, 32'd0);
        step(5);
        check_eq("dis.pwm_later", {31'd0, pwm_out}, 32'd0);
        enable = 1'b1;
        run_frame("reen", 100, 1'b0);
        check_eq("reen.ready", {31'd0, bus.sample_ready}, 32'd1);

        // Reset mid-frame discards the pending sample and the duty.
        step(5);
        produce("p200", 8'd200, 4, w_x, f_x);
        bus.sample_valid = 1'b0;
        nRst = 1'b0;
        step(1);
        check_eq("mrst.pwm", {31'd0, pwm_out}, 32'd0);
        check_eq("mrst.fs", {31'd0, frame_start}, 32'd0);
        check_eq("mrst.ur", {31'd0, underrun}, 32'd0);
        check_eq("mrst.ready", {31'd0, bus.sample_ready}, 32'd1);
        nRst = 1'b1;
        run_frame("after_rst", 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
